// File: rtl/riscv_defs.sv
// riscv_defs: shared definitions for the load/store memory access path.
//   - opcode constants for loads and stores
//   - access-size encodings taken from funct3[1:0]
//   - FSM state encoding for mem_access_unit
//   - default bus-timeout length
//   - alignment helper used by the issue logic
package riscv_defs;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int unsigned TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StDone = 2'b10
   } mau_state_t;

   // Byte accesses are always aligned; halves need an even address,
   // words (and any wider/unknown size) need a 4-byte aligned address.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
      logic ok;
      case (size)
         SIZE_BYTE: ok = 1'b1;
         SIZE_HALF: ok = ~lo[0];
         default:   ok = (lo == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: combinational store lane placement.
// Ports:
//   size      in  2      access size (byte/half/word)
//   addr_lo   in  2      byte offset within the word
//   wdata     in  WIDTH  raw store data (rs2)
//   be        out 4      byte enables
//   lane_data out WIDTH  store data replicated across all lanes
module store_lane_align
   import riscv_defs::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       size,
   input  logic [1:0]       addr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic [3:0]       be,
   output logic [WIDTH-1:0] lane_data
);

   // Data is replicated so the enabled lanes carry the right bytes no matter
   // which offset is addressed; the byte enables select the lanes written.
   always_comb begin
      be        = 4'b1111;
      lane_data = wdata;
      case (size)
         SIZE_BYTE: begin
            be        = 4'b0001 << addr_lo;
            lane_data = {(WIDTH/8){wdata[7:0]}};
         end
         SIZE_HALF: begin
            be        = 4'b0011 << addr_lo;
            lane_data = {(WIDTH/16){wdata[15:0]}};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer (IDLE -> REQ -> DONE).
// Optional feature macro: MEM_TIMEOUT_EN (bus timeout -> bus_err pulse).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   inst, addr, wdata          instruction, effective address, store data
//   valid_in                   inputs valid this cycle
//   stall_out                  hold upstream pipeline
//   dmem_req/we/addr/be/wdata  memory request interface
//   dmem_ack, dmem_rdata       memory response
//   data_out                   read word shifted so addressed byte/half is at bit 0
//   data_valid, misalign, bus_err  one-cycle status pulses
module mem_access_unit
   import riscv_defs::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] inst,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             valid_in,
   output logic             stall_out,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [3:0]       dmem_be,
   output logic [WIDTH-1:0] dmem_wdata,
   input  logic             dmem_ack,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             misalign,
   output logic             bus_err
);

   mau_state_t       state_q, state_d;
   logic             accept, misalign_d, misalign_q;
   logic             is_load, is_store, is_mem, aligned;
   logic [1:0]       size;
   logic [3:0]       st_be;
   logic [WIDTH-1:0] st_data;

   logic             we_q, is_load_q;
   logic [1:0]       addr_lo_q;
   logic [3:0]       be_q;
   logic [WIDTH-1:0] addr_q, wdata_q, data_out_q;

   logic unused_inst;
   assign unused_inst = ^{inst[WIDTH-1:15], inst[11:7]};

   assign is_load  = (inst[6:0] == OPC_LOAD);
   assign is_store = (inst[6:0] == OPC_STORE);
   assign is_mem   = is_load | is_store;
   // funct3 100/101 (unsigned loads) map onto byte/half through the low bits.
   assign size     = inst[13:12];
   assign aligned  = is_aligned(size, addr[1:0]);

   store_lane_align #(
      .WIDTH(WIDTH)
   ) u_store_lane_align (
      .size     (size),
      .addr_lo  (addr[1:0]),
      .wdata    (wdata),
      .be       (st_be),
      .lane_data(st_data)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   logic [CntW-1:0] tmo_cnt_q;
   logic            tmo_hit, bus_err_d, bus_err_q;

   assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= bus_err_d;
         if (accept) begin
            tmo_cnt_q <= '0;
         end else if (state_q == StReq) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
      end
   end

   assign bus_err = bus_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign bus_err        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_d  = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            // rst_n gating keeps stall_out low while reset is held.
            if (rst_n && valid_in && is_mem) begin
               if (aligned) begin
                  accept  = 1'b1;
                  state_d = StReq;
               end else begin
                  misalign_d = 1'b1;
               end
            end
         end
         StReq: begin
            if (dmem_ack) begin
               state_d = StDone;
`ifdef MEM_TIMEOUT_EN
            end else if (tmo_hit) begin
               state_d   = StIdle;
               bus_err_d = 1'b1;
`endif
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         misalign_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= 4'b0000;
         we_q       <= 1'b0;
         is_load_q  <= 1'b0;
         addr_lo_q  <= 2'b00;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         misalign_q <= misalign_d;
         if (accept) begin
            addr_q    <= {addr[WIDTH-1:2], 2'b00};
            wdata_q   <= is_store ? st_data : '0;
            be_q      <= is_store ? st_be : 4'b1111;
            we_q      <= is_store;
            is_load_q <= is_load;
            addr_lo_q <= addr[1:0];
         end
         if ((state_q == StReq) && dmem_ack && is_load_q) begin
            data_out_q <= dmem_rdata >> {addr_lo_q, 3'b000};
         end
      end
   end

   assign dmem_req   = (state_q == StReq);
   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;
   assign stall_out  = dmem_req | accept;
   assign data_out   = data_out_q;
   assign data_valid = (state_q == StDone) & is_load_q;
   assign misalign   = misalign_q;

endmodule
